// File: rtl/pwm_seq_pkg.sv
// Shared state encoding for the PWM ramp sequencer and its prescaler.
package pwm_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_seq_tick.sv
// Step prescaler: counts 0..div while enabled and pulses tick on the terminal count.
module pwm_seq_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Ramp-up / hold / ramp-down duty sequencer feeding a PWM load input.
// Define PWM_SEQ_BREATHE_EN to loop completed ramp-downs back into RAMP_UP.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int LOAD_W = 3,
  parameter int DIV_W  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic [LOAD_W-1:0] max_level,
  output logic [LOAD_W-1:0] load,
  output logic              busy,
  output logic              done
);

  state_t              state, state_nxt;
  logic [LOAD_W-1:0]   load_nxt, max_q;
  logic [DIV_W-1:0]    div_q;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt, hold_q;
  logic                done_nxt, accept, tick, abort_go;

  assign busy     = (state != IDLE);
  assign abort_go = stop && ((state == RAMP_UP) || (state == HOLD));

  pwm_seq_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (busy),
    .div   (div_q),
    .tick  (tick)
  );

`ifdef PWM_SEQ_BREATHE_EN
  // Remembers that this ramp-down was forced by stop, so it ends in IDLE.
  logic aborted;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         aborted <= 1'b0;
    else if (accept)   aborted <= 1'b0;
    else if (abort_go) aborted <= 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    load_nxt  = load;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept    = 1'b1;
          state_nxt = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (abort_go) state_nxt = RAMP_DOWN;
        else if (tick) begin
          if (load < max_q) load_nxt = load + 1'b1;
          else begin
            state_nxt = HOLD;
            hold_nxt  = '0;
          end
        end
      end
      HOLD: begin
        if (abort_go) state_nxt = RAMP_DOWN;
        else if (tick) begin
          if (hold_cnt == hold_q) state_nxt = RAMP_DOWN;
          else                    hold_nxt  = hold_cnt + 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          if (load != '0) load_nxt = load - 1'b1;
          else begin
            done_nxt = 1'b1;
`ifdef PWM_SEQ_BREATHE_EN
            state_nxt = aborted ? IDLE : RAMP_UP;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      load     <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
      div_q    <= '0;
      hold_q   <= '0;
      max_q    <= '0;
    end else begin
      state    <= state_nxt;
      load     <= load_nxt;
      hold_cnt <= hold_nxt;
      done     <= done_nxt;
      if (accept) begin
        div_q  <= div;
        hold_q <= hold_len;
        max_q  <= max_level;
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench: closed-form trajectory model plus directed literal checks.
module tb_pwm_ramp_sequencer;

  localparam int LOAD_W = 3;
  localparam int DIV_W  = 8;
  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [DIV_W-1:0]  div = '0;
  logic [HOLD_W-1:0] hold_len = '0;
  logic [LOAD_W-1:0] max_level = '0;
  logic [LOAD_W-1:0] load;
  logic              busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(.LOAD_W(LOAD_W), .DIV_W(DIV_W), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .div       (div),
    .hold_len  (hold_len),
    .max_level (max_level),
    .load      (load),
    .busy      (busy),
    .done      (done)
  );

  // Model: m_k counts cycles since the accepted start; ticks completed = m_k/(div+1).
  // A full sequence is 2*max+hold+3 ticks; the level is a piecewise function of ticks.
  bit m_act, m_done, m_ab;
  int m_k, m_div, m_hold, m_max, m_t0, m_L;

  function automatic int lvl_norm(int nn, int mx, int hd);
    if (nn <= mx)          return nn;
    else if (nn <= mx+hd+2) return mx;
    else                   return mx - (nn - (mx + hd + 2));
  endfunction

  function automatic int seq_len();
    return 2*m_max + m_hold + 3;
  endfunction

  function automatic int exp_load();
    int n;
    if (!m_act) return 0;
    n = m_k / (m_div + 1);
    if (m_ab) return m_L - (n - m_t0);
`ifdef PWM_SEQ_BREATHE_EN
    return lvl_norm(n % seq_len(), m_max, m_hold);
`else
    return lvl_norm(n, m_max, m_hold);
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_done = 0; m_ab = 0; m_k = 0;
    end else begin
      bit d, tk;
      int p, n, nn;
      d = 0;
      if (!m_act) begin
        if (start && !stop) begin
          m_act = 1; m_k = 0; m_ab = 0;
          m_div = int'(div); m_hold = int'(hold_len); m_max = int'(max_level);
        end
      end else begin
        p  = m_div + 1;
        n  = m_k / p;
        tk = (m_k % p) == (p - 1);
        if (!m_ab) begin
`ifdef PWM_SEQ_BREATHE_EN
          nn = n % seq_len();
`else
          nn = n;
`endif
          if (stop && nn <= m_max + m_hold + 1) begin
            m_ab = 1;
            m_L  = lvl_norm(nn, m_max, m_hold);
            m_t0 = n + (tk ? 1 : 0);
            m_k++;
          end else if (tk && nn == seq_len() - 1) begin
            d = 1;
`ifdef PWM_SEQ_BREATHE_EN
            m_k++;
`else
            m_act = 0;
`endif
          end else m_k++;
        end else begin
          if (tk && (n - m_t0) == m_L) begin
            d = 1; m_act = 0;
          end else m_k++;
        end
      end
      m_done = d;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the DUT against the model.
  task automatic cycle();
    logic [LOAD_W-1:0] el;
    @(negedge clk);
    if (!reset) begin
      el = LOAD_W'(exp_load());
      tests++;
      if (load !== el || busy !== m_act || done !== m_done) begin
        fails++;
        $display("FAIL model_cmp t=%0t: load=%0d busy=%0b done=%0b, expected load=%0d busy=%0b done=%0b",
                 $time, load, busy, done, el, m_act, m_done);
      end
    end
  endtask

  task automatic start_seq(input int d, input int h, input int m);
    div = DIV_W'(d); hold_len = HOLD_W'(h); max_level = LOAD_W'(m);
    start = 1'b1; stop = 1'b0;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_seq();
    bit idle;
    idle = 0;
    stop = 1'b1;
    for (int i = 0; i < 200 && !idle; i++) begin
      cycle();
      if (!busy) idle = 1;
    end
    check("finish_idle", int'(idle), 1);
    stop = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp30[20] = '{0,1,2,3,4,5,6,7,7,7,7,7,6,5,4,3,2,1,0,0};
    int lv[17], dn[17], bz[17];
    int done_k, ndone, prev, c1, c2, peak;
    bit found;

    // Reset state
    repeat (3) cycle();
    #1;
    check("reset_load", int'(load), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset = 1'b0;
    cycle();

    // Full sequence, div=0, max=7, hold=2
    done_k = -1; ndone = 0;
    start_seq(0, 2, 7);
    check("r030_busy_k0", int'(busy), 1);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cycle();
      check($sformatf("r030_load_k%0d", k), int'(load), exp30[k]);
      if (done) begin ndone++; done_k = k; end
    end
    check("r030_done_cycle", done_k, 19);
    check("r030_done_count", ndone, 1);
    cycle();
`ifdef PWM_SEQ_BREATHE_EN
    check("r030_busy_after", int'(busy), 1);
`else
    check("r030_busy_after", int'(busy), 0);
`endif
    finish_seq();

    // Step spacing with div=3
    prev = 0; c1 = -1; c2 = -1;
    start_seq(3, 0, 2);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) cycle();
      if (int'(load) != prev) begin
        if (c1 < 0) c1 = k; else if (c2 < 0) c2 = k;
        prev = int'(load);
      end
    end
    check("r031_first_step", c1, 4);
    check("r031_step_gap", c2 - c1, 4);
    finish_seq();

    // Stop in HOLD at load=5
    start_seq(0, 6, 5);
    lv[0] = int'(load); dn[0] = int'(done); bz[0] = int'(busy);
    for (int k = 1; k < 17; k++) begin
      cycle();
      lv[k] = int'(load); dn[k] = int'(done); bz[k] = int'(busy);
      if (k == 8) stop = 1'b1;
    end
    stop = 1'b0;
    check("r032_hold_load", lv[8], 5);
    check("r032_stop_held", lv[9], 5);
    check("r032_first_dec", lv[10], 4);
    check("r032_reach_zero", lv[14], 0);
    ndone = 0;
    for (int k = 9; k < 17; k++) ndone += dn[k];
    check("r032_done_count", ndone, 1);
    check("r032_done_k15", dn[15], 1);
    check("r032_idle", bz[16], 0);

    // Reset mid RAMP_UP at load=4
    found = 0;
    start_seq(1, 0, 7);
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (load == 3'd4) found = 1;
    end
    check("r033_reached_4", int'(found), 1);
    #1 reset = 1'b1;
    #1;
    check("r033_async_load", int'(load), 0);
    check("r033_async_busy", int'(busy), 0);
    check("r033_async_done", int'(done), 0);
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    start_seq(1, 0, 7);
    check("r033_restart_k0", int'(load), 0);
    cycle(); cycle();
    check("r033_restart_k2", int'(load), 1);
    finish_seq();

    // start with stop in IDLE, then mid-sequence max_level change
    start = 1'b1; stop = 1'b1;
    cycle(); cycle(); cycle();
    check("r034_start_stop_idle", int'(busy), 0);
    start = 1'b0; stop = 1'b0;
    start_seq(0, 1, 3);
    max_level = 3'd7;
    peak = int'(load);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (int'(load) > peak) peak = int'(load);
    end
    check("r034_peak_captured", peak, 3);
    finish_seq();

`ifdef PWM_SEQ_BREATHE_EN
    begin
      int exp35[10] = '{0,1,1,1,0,0,1,1,1,0};
      int nidle;
      nidle = 0; ndone = 0; done_k = -1;
      start_seq(0, 0, 1);
      for (int k = 0; k < 10; k++) begin
        if (k > 0) cycle();
        check($sformatf("r035_load_k%0d", k), int'(load), exp35[k]);
        if (done) begin ndone++; done_k = k; end
        if (!busy) nidle++;
      end
      check("r035_done_k", done_k, 5);
      check("r035_done_count", ndone, 1);
      check("r035_busy_stays", nidle, 0);
      finish_seq();
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      div       = DIV_W'($urandom_range(0, 3));
      hold_len  = HOLD_W'($urandom_range(0, 3));
      max_level = LOAD_W'($urandom_range(0, 7));
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    finish_seq();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
